serie_paralelo_align: RTL

Parametrised serial-to-parallel converter for the PHY receive path. It recovers word alignment on its own by sliding-window comma search, with no external word clock. Alignment is qualified by a lock state machine with hysteresis. Aligned non-comma words are presented as single-cycle valid pulses to the downstream byte-striping logic.

---
 rtl/serie_paralelo_pkg.sv | 24 ++
 rtl/sp_lock_fsm.sv | 84 ++++++++
 rtl/serie_paralelo_align.sv | 80 ++++++++
 3 files changed

// File: rtl/serie_paralelo_pkg.sv
// Shared state encoding, default comma word and counter helpers for the
// serial-to-parallel word aligner.
package serie_paralelo_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } sp_state_t;

    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;
    localparam int         CNT_W         = 4;

    // Saturating increment: counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    // True when this increment is the one that reaches the target count.
    function automatic logic last_step(input logic [CNT_W-1:0] c, input int target);
        return (int'(c) + 1) == target;
    endfunction

endpackage

// File: rtl/sp_lock_fsm.sv
// Lock qualification for the word aligner: SEARCH -> ALIGN -> LOCKED with
// separate aligned-comma and misaligned-comma counters for hysteresis.
module sp_lock_fsm
    import serie_paralelo_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2
) (
    input  logic      clk_8f,
    input  logic      reset,
    input  logic      comma_hit,
    input  logic      boundary,
    output sp_state_t state,
    output logic      ph_load,
    output logic      locked
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] err;

    // A comma seen while searching defines the word phase: the next boundary
    // is one full word later, so the phase counter is loaded with 1.
    assign ph_load = (state == SEARCH) && comma_hit;

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state  <= SEARCH;
            cnt    <= '0;
            err    <= '0;
            locked <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (comma_hit) begin
                        cnt <= CNT_W'(1);
                        err <= '0;
                        if (LOCK_COUNT == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (boundary) begin
                        if (comma_hit) begin
                            cnt <= sat_inc(cnt);
                            if (last_step(cnt, LOCK_COUNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                err    <= '0;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    // An aligned comma forgives earlier misaligned ones.
                    if (boundary) begin
                        if (comma_hit) begin
                            err <= '0;
                        end
                    end else if (comma_hit) begin
                        err <= sat_inc(err);
                        if (last_step(err, LOSS_COUNT)) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            cnt    <= '0;
                            err    <= '0;
                        end
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/serie_paralelo_align.sv
// Serial-to-parallel converter with self-aligning comma search; emits one
// valid pulse per aligned non-comma word while locked.
module serie_paralelo_align
    import serie_paralelo_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEFAULT),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 2
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             valid_out,
    output logic             locked,
    output logic             comma_det
);

    localparam int             PH_W    = $clog2(WIDTH);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [PH_W-1:0]  ph;
    logic             comma_hit;
    logic             boundary;
    logic             ph_load;
    sp_state_t        state;

    assign comma_hit = (sr == COMMA);
    assign boundary  = (ph == '0);

    sp_lock_fsm #(
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    ) u_lock_fsm (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .comma_hit (comma_hit),
        .boundary  (boundary),
        .state     (state),
        .ph_load   (ph_load),
        .locked    (locked)
    );

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            sr <= '0;
            ph <= '0;
        end else begin
            sr <= {sr[WIDTH-2:0], data_in};
            if (ph_load) begin
                ph <= PH_W'(1);
            end else if (ph == PH_LAST) begin
                ph <= '0;
            end else begin
                ph <= ph + 1'b1;
            end
        end
    end

    // Output stage: registered word/valid one cycle after the boundary cycle.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            parallel_out <= '0;
            valid_out    <= 1'b0;
            comma_det    <= 1'b0;
        end else begin
            comma_det <= comma_hit;
            if ((state == LOCKED) && boundary && !comma_hit) begin
                parallel_out <= sr;
                valid_out    <= 1'b1;
            end else begin
                parallel_out <= '0;
                valid_out    <= 1'b0;
            end
        end
    end

endmodule
